// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
// Optional embedded checks: define MULT_ARB_ASSERT_EN.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_arb_state_e;

  localparam int MULT_ARB_MAX_REQ = 16;

  function automatic int id_w(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/mult_core.sv
// Sequential shift-add multiplier, one operand bit per cycle.
// Optional embedded checks: define MULT_ARB_ASSERT_EN.
module mult_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] a_sr;
  logic [PW-1:0]    b_sr;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_nxt;
  logic [CW-1:0]    cnt;
  logic             run;

  assign acc_nxt = acc + (a_sr[0] ? b_sr : '0);
  assign done    = run && (cnt == CW'(WIDTH - 1));
  assign prod    = acc_nxt;

  // Bit 0 is folded into the load so the last bit lands on the DONE edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sr <= '0;
      b_sr <= '0;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      a_sr <= a >> 1;
      b_sr <= {{(WIDTH-1){1'b0}}, b, 1'b0};
      acc  <= a[0] ? {{WIDTH{1'b0}}, b} : '0;
      cnt  <= CW'(1);
      run  <= 1'b1;
    end else if (run) begin
      acc  <= acc_nxt;
      a_sr <= a_sr >> 1;
      b_sr <= b_sr << 1;
      if (done) begin
        run <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef MULT_ARB_ASSERT_EN
  a_acc_mono: assert property (
    @(posedge clk) disable iff (!rst)
    (run && !start) |=> (acc >= $past(acc))
  );
`endif

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one shift-add multiplier core.
// Optional embedded checks: define MULT_ARB_ASSERT_EN.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2*WIDTH-1:0]       rsp_prod,
  output logic [id_w(N_REQ)-1:0]   rsp_id,
  output logic                     busy
);

  localparam int IW = id_w(N_REQ);

  mult_arb_state_e state;

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      nxt_ptr;
  logic               found;
  logic               accept;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               core_done;
  logic [2*WIDTH-1:0] core_prod;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    j       = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      if (!found && req_valid[j]) begin
        found   = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  assign req_ready = (rst && state == IDLE && found)
                   ? (N_REQ'(1) << gnt_idx) : '0;
  assign accept    = |(req_valid & req_ready);
  assign nxt_ptr   = (gnt_idx == IW'(N_REQ - 1))
                   ? '0 : gnt_idx + IW'(1);

  assign sel_a = req_a[gnt_idx*WIDTH +: WIDTH];
  assign sel_b = req_b[gnt_idx*WIDTH +: WIDTH];

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);

  mult_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .a     (sel_a),
    .b     (sel_b),
    .done  (core_done),
    .prod  (core_prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      rsp_prod <= '0;
      rsp_id   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state  <= RUN;
            rr_ptr <= nxt_ptr;
            rsp_id <= gnt_idx;
          end
        end
        RUN: begin
          if (core_done) begin
            state    <= DONE;
            rsp_prod <= core_prod;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT_ARB_ASSERT_EN
  logic [2*WIDTH-1:0] exp_prod;
  logic [4:0]         wait_cnt [N_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_prod <= '0;
    end else if (accept) begin
      exp_prod <= (2*WIDTH)'(sel_a) * (2*WIDTH)'(sel_b);
    end
  end

  // Accepts granted to others while a requester keeps waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i] || req_ready[i]) begin
          wait_cnt[i] <= '0;
        end else if (accept) begin
          wait_cnt[i] <= wait_cnt[i] + 5'd1;
        end
      end
    end
  end

  a_onehot: assert property (
    @(posedge clk) disable iff (!rst)
    $onehot0(req_ready)
  );

  a_prod: assert property (
    @(posedge clk) disable iff (!rst)
    rsp_valid |-> (rsp_prod == exp_prod)
  );

  a_stable: assert property (
    @(posedge clk) disable iff (!rst)
    (rsp_valid && !rsp_ready) |=>
      ($stable(rsp_prod) && $stable(rsp_id))
  );

  a_busy: assert property (
    @(posedge clk) disable iff (!rst)
    busy == (state != IDLE)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_starve
    a_starve: assert property (
      @(posedge clk) disable iff (!rst)
      int'(wait_cnt[g]) < N_REQ
    );
  end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: vector table plus corner sequences.
module tb_mult_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int IW    = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [2*WIDTH-1:0]     rsp_prod;
  logic [IW-1:0]          rsp_id;
  logic                   busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_arbiter #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  typedef struct {
    int id;
    int a;
    int b;
    int stall;
    int prod;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input int a, input int b);
    req_valid[id]              = 1'b1;
    req_a[id*WIDTH +: WIDTH]   = WIDTH'(a);
    req_b[id*WIDTH +: WIDTH]   = WIDTH'(b);
  endtask

  // Called in cycle 1 (just after the accept edge).
  task automatic wait_rsp(input string name,
                          input int exp_prod,
                          input int exp_id);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      tick();
      lat++;
    end
    chk({name, " latency"}, lat, WIDTH);
    chk({name, " prod"}, 32'(rsp_prod), exp_prod);
    chk({name, " id"}, 32'(rsp_id), exp_id);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic bad;
    req_valid = '0;
    set_req(v.id, v.a, v.b);
    rsp_ready = (v.stall == 0);
    #1;
    chk({name, " grant"}, 32'(req_ready), 32'(1) << v.id);
    tick();
    req_valid = '0;
    req_a     = '1;
    req_b     = '1;
    chk({name, " busy"}, 32'(busy), 1);
    wait_rsp(name, v.prod, v.id);
    if (v.stall > 0) begin
      bad       = 1'b0;
      req_valid = '1;
      #1;
      for (int s = 0; s < v.stall; s++) begin
        if (!rsp_valid || rsp_prod !== 16'(v.prod) ||
            rsp_id !== IW'(v.id) || req_ready !== '0)
          bad = 1'b1;
        tick();
      end
      if (!rsp_valid || rsp_prod !== 16'(v.prod) ||
          rsp_id !== IW'(v.id) || req_ready !== '0)
        bad = 1'b1;
      chk({name, " stall hold"}, 32'(bad), 0);
      req_valid = '0;
      rsp_ready = 1'b1;
    end
    tick();
    chk({name, " idle"}, {30'd0, busy, rsp_valid}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    logic bad;
    int   last;
    int   t;
    int   e;

    vecs[0] = '{id: 2, a: 13,  b: 11,  stall: 0, prod: 143};
    vecs[1] = '{id: 0, a: 0,   b: 200, stall: 0, prod: 0};
    vecs[2] = '{id: 3, a: 255, b: 255, stall: 5, prod: 65025};
    vecs[3] = '{id: 1, a: 1,   b: 1,   stall: 0, prod: 1};
    vecs[4] = '{id: 0, a: 128, b: 2,   stall: 0, prod: 256};
    vecs[5] = '{id: 3, a: 200, b: 0,   stall: 0, prod: 0};
    vecs[6] = '{id: 1, a: 170, b: 85,  stall: 2, prod: 14450};

    rst       = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    chk("reset req_ready", 32'(req_ready), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_prod", 32'(rsp_prod), 0);
    chk("reset rsp_id", 32'(rsp_id), 0);

    req_valid = '0;
    rst       = 1'b1;
    bad       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy !== 1'b0 || rsp_valid !== 1'b0 ||
          rsp_prod !== '0 || rsp_id !== '0 || req_ready !== '0)
        bad = 1'b1;
    end
    chk("quiet after reset", 32'(bad), 0);

    foreach (vecs[i]) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Restart rr_ptr from 0 for the rotation test.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < N_REQ; i++) begin
      set_req(i, i + 1, 255);
    end
    rsp_ready = 1'b1;
    #1;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      e = g % N_REQ;
      t = 0;
      while (req_ready == '0 && t < 20) begin
        tick();
        t++;
      end
      chk($sformatf("rr%0d grant", g), 32'(req_ready), 32'(1) << e);
      if (g > 0) begin
        chk($sformatf("rr%0d spacing", g), cyc - last, WIDTH + 1);
      end
      last = cyc;
      tick();
      wait_rsp($sformatf("rr%0d", g), (e + 1) * 255, e);
      tick();
    end
    req_valid = '0;
    tick();
    chk("rr drained", 32'(busy), 0);

    // Reset in cycle 4 of RUN, then requester 1 must win from rr_ptr 0.
    set_req(1, 200, 100);
    #1;
    chk("midrst grant", 32'(req_ready), 2);
    tick();
    req_valid = '0;
    repeat (3) tick();
    chk("midrst running", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst rsp_valid", 32'(rsp_valid), 0);
    tick();
    rst = 1'b1;
    set_req(1, 3, 5);
    set_req(3, 7, 7);
    #1;
    chk("postrst grant", 32'(req_ready), 2);
    tick();
    req_valid = '0;
    wait_rsp("postrst", 15, 1);
    tick();
    chk("postrst idle", {30'd0, busy, rsp_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
